// File: rtl/hazard_unit_v.sv
// Hazard unit for the 5-stage vector pipeline: operand forwarding, load-use and
// branch stall/flush control, plus a registered sequencer for multi-beat vector memory ops.
`timescale 1ns/1ps
module hazard_unit_v #(
  parameter int REG_ADDR_W = 4,
  parameter int VMEM_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  BranchTakenE,
  input  logic                  VMemStartM,
  input  logic                  VMemAck,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  VBusy
);

  localparam int CNT_W = $clog2(VMEM_BEATS + 1);

  typedef enum logic {RUN = 1'b0, VMEM = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             vbusy_q;
  logic             ld_stall;

  // The M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] ra,
    input logic [REG_ADDR_W-1:0] wa_m,
    input logic [REG_ADDR_W-1:0] wa_w,
    input logic                  we_m,
    input logic                  we_w
  );
    if (we_m && (wa_m == ra))      return 2'b10;
    else if (we_w && (wa_w == ra)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign ld_stall = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      vbusy_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (VMemStartM) begin
            state   <= VMEM;
            cnt     <= CNT_W'(VMEM_BEATS);
            vbusy_q <= 1'b1;
          end
        end
        VMEM: begin
          // Further start pulses are ignored: M is frozen while beats drain.
          if (VMemAck && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state   <= RUN;
              vbusy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    VBusy     = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
      VBusy     = vbusy_q;
      if (state == VMEM) begin
        // Whole front end frozen; a bubble into W avoids a duplicate writeback.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ld_stall;
        StallD = ld_stall;
        FlushE = ld_stall | BranchTakenE;
        FlushD = BranchTakenE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_v.sv
// Bench for hazard_unit_v: vector table for the combinational rules plus
// hand-built sequences for the vector-memory sequencer, checked through a queue.
`timescale 1ns/1ps
module tb_hazard_unit_v;

  localparam logic [6:0] C_RST = 7'b1000000;
  localparam logic [6:0] C_RWM = 7'b0100000;
  localparam logic [6:0] C_RWW = 7'b0010000;
  localparam logic [6:0] C_M2R = 7'b0001000;
  localparam logic [6:0] C_BR  = 7'b0000100;
  localparam logic [6:0] C_VS  = 7'b0000010;
  localparam logic [6:0] C_VA  = 7'b0000001;

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, VBusy}
  localparam logic [11:0] E_RUN  = 12'h000;
  localparam logic [11:0] E_VM   = 12'h0F3;
  localparam logic [11:0] E_RST  = 12'h00E;
  localparam logic [11:0] E_BR   = 12'h00C;
  localparam logic [11:0] E_LD   = 12'h0C4;
  localparam logic [11:0] E_BRLD = 12'h0CC;
  localparam logic [11:0] FA10   = 12'h800;
  localparam logic [11:0] FA01   = 12'h400;
  localparam logic [11:0] FB10   = 12'h200;
  localparam logic [11:0] FB01   = 12'h100;

  typedef struct {
    string      name;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic [6:0] ctl;
    logic [11:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, VMemStartM, VMemAck;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, VBusy;
  logic [11:0] got;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  hazard_unit_v #(.REG_ADDR_W(4), .VMEM_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .VMemStartM(VMemStartM), .VMemAck(VMemAck),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .VBusy(VBusy)
  );

  always #5 clk = ~clk;

  assign got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, VBusy};

  function automatic vec_t mkv(input string nm,
                               input logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
                               input logic [6:0] ctl, input logic [11:0] exp);
    vec_t v;
    v.name = nm;
    v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
    v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
    v.ctl  = ctl;  v.exp  = exp;
    return v;
  endfunction

  function automatic vec_t c(input string nm, input logic [6:0] ctl, input logic [11:0] exp);
    return mkv(nm, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, ctl, exp);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
    {reset, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, VMemStartM, VMemAck} = v.ctl;
    sb_q.push_back(v);
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %03h required an entry", got);
    end else begin
      e = sb_q.pop_front();
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %03h required %03h", e.name, got, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Combinational rules, all applied in RUN with no vector op starting.
    tbl.push_back(mkv("fwd_m_priority", 0, 0, 3, 5, 0, 3, 3, C_RWM | C_RWW, FA10));
    tbl.push_back(mkv("fwd_w_only",     0, 0, 3, 5, 0, 3, 3, C_RWW, FA01));
    tbl.push_back(mkv("fwd_both_w",     0, 0, 3, 3, 0, 3, 3, C_RWW, FA01 | FB01));
    tbl.push_back(mkv("fwd_both_m",     0, 0, 3, 3, 0, 3, 3, C_RWM, FA10 | FB10));
    tbl.push_back(mkv("fwd_m_nomatch",  0, 0, 3, 5, 0, 4, 3, C_RWM | C_RWW, FA01));
    tbl.push_back(mkv("fwd_b_m_a_w",    0, 0, 3, 6, 0, 6, 3, C_RWM | C_RWW, FA01 | FB10));
    tbl.push_back(mkv("fwd_reg0",       0, 0, 0, 9, 0, 0, 0, C_RWM, FA10));
    tbl.push_back(mkv("lduse_rb",       7, 2, 0, 0, 2, 9, 9, C_M2R, E_LD));
    tbl.push_back(mkv("lduse_clear",    7, 2, 0, 0, 2, 9, 9, 7'b0, E_RUN));
    tbl.push_back(mkv("lduse_ra",       2, 8, 0, 0, 2, 9, 9, C_M2R, E_LD));
    tbl.push_back(mkv("load_nomatch",   3, 4, 0, 0, 2, 9, 9, C_M2R, E_RUN));
    tbl.push_back(mkv("branch",         3, 4, 0, 0, 2, 9, 9, C_BR, E_BR));
    tbl.push_back(mkv("branch_lduse",   2, 4, 0, 0, 2, 9, 9, C_BR | C_M2R, E_BRLD));

    apply(mkv("reset_forced", 0, 0, 3, 3, 0, 3, 3, C_RST | C_RWM | C_BR | C_M2R, E_RST));
    apply(c("reset_idle", C_RST, E_RST));
    apply(c("run_idle", 7'b0, E_RUN));
    apply(c("ack_in_run", C_VA, E_RUN));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Vector op with acks every cycle: exactly four frozen cycles.
    apply(c("hold_start", C_VS, E_RUN));
    for (int i = 0; i < 4; i++) apply(c("hold_vmem", C_VA, E_VM));
    apply(c("hold_exit", 7'b0, E_RUN));

    // Acks on alternate cycles: eight frozen cycles; stray start, forwarding and
    // load-use inputs inside the op must not disturb the sequence.
    apply(c("alt_start", C_VS, E_RUN));
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      apply(c("alt_restart_ign", C_VS, E_VM));
      else if (i == 4) apply(mkv("alt_fwd_vmem", 0, 0, 3, 0, 0, 3, 0, C_RWM, E_VM | FA10));
      else if (i == 5) apply(c("alt_lduse_ign", C_M2R | C_VA, E_VM));
      else             apply(c("alt_vmem", (i % 2 == 1) ? C_VA : 7'b0, E_VM));
    end
    apply(c("alt_exit", 7'b0, E_RUN));

    // Branch held across the whole op resolves on the first RUN cycle.
    apply(c("br_start", C_BR | C_VS, E_BR));
    for (int i = 0; i < 4; i++) apply(c("br_hold_vmem", C_BR | C_VA, E_VM));
    apply(c("br_resolve", C_BR, E_BR));
    apply(c("br_done", 7'b0, E_RUN));

    // Reset in the middle of an op, then a fresh op runs its full count.
    apply(c("rs_start", C_VS, E_RUN));
    for (int i = 0; i < 2; i++) apply(c("rs_ack", C_VA, E_VM));
    apply(c("rs_reset", C_RST | C_VA, E_RST));
    apply(c("rs_after", C_VA, E_RUN));
    apply(c("rs_restart", C_VS, E_RUN));
    for (int i = 0; i < 4; i++) apply(c("rs_full_vmem", C_VA, E_VM));
    apply(c("rs_full_exit", 7'b0, E_RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
